// File: rtl/dvs_rst_req_rx.sv
// dvs_rst_req_rx: receive-side reset qualifier.
// Synchronises an asynchronous, active-low reset request into clk. Requests
// shorter than MIN_WIDTH are rejected as glitches; qualified requests drive a
// registered synchronous reset that is held for STRETCH cycles after release.
//
// Ports:
//   clk          single clock
//   rst          synchronous active-high local reset
//   rst_req_n_i  asynchronous active-low reset request
//   rst_o        qualified active-high reset, registered
//   rst_n_o      complement of rst_o, registered
//   glitch_o     1-cycle pulse when a request is rejected as too short
//   rst_cnt_o    saturating count of qualified reset events
//   busy_o       FSM is not idle
//   req_width_o  (DVS_RST_REQ_RX_WIDTH_MEAS_EN only) width of the last request, saturating
//
// Optional feature macro: DVS_RST_REQ_RX_WIDTH_MEAS_EN
module dvs_rst_req_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_WIDTH   = 4,
  parameter int STRETCH     = 16,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rst_req_n_i,
  output logic             rst_o,
  output logic             rst_n_o,
  output logic             glitch_o,
  output logic [CNT_W-1:0] rst_cnt_o,
  output logic             busy_o
`ifdef DVS_RST_REQ_RX_WIDTH_MEAS_EN
  ,
  output logic [CNT_W-1:0] req_width_o
`endif
);

  // Shared counter only ever needs to reach max(MIN_WIDTH,STRETCH)-1.
  localparam int MAXC = (MIN_WIDTH > STRETCH) ? MIN_WIDTH : STRETCH;
  localparam int CW   = (MAXC < 2) ? 1 : $clog2(MAXC);
  localparam logic [CW-1:0] MW_LAST = CW'(MIN_WIDTH - 1);
  localparam logic [CW-1:0] ST_LAST = CW'(STRETCH - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILTER, S_ASSERT, S_STRETCH} state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_req;
  state_t                 r_state, w_nxt;
  logic [CW-1:0]          r_cnt, w_cnt_nxt;
  logic                   w_glitch, w_inc;
  logic                   r_rst, r_rst_n, r_glitch;
  logic [CNT_W-1:0]       r_rst_cnt;

  // Synchroniser: no async reset; the local reset just forces "inactive".
  always_ff @(posedge clk) begin
    if (rst) r_sync <= '1;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], rst_req_n_i};
  end

  assign w_req = ~r_sync[SYNC_STAGES-1];

  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = r_cnt;
    w_glitch  = 1'b0;
    w_inc     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (MIN_WIDTH == 1) begin
            w_nxt = S_ASSERT;
            w_inc = 1'b1;
          end else begin
            // The IDLE sample counts as the first active sample.
            w_nxt     = S_FILTER;
            w_cnt_nxt = CW'(1);
          end
        end
      end
      S_FILTER: begin
        if (!w_req) begin
          w_nxt    = S_IDLE;
          w_glitch = 1'b1;
        end else if (r_cnt == MW_LAST) begin
          w_nxt = S_ASSERT;
          w_inc = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_ASSERT: begin
        if (!w_req) begin
          w_nxt     = S_STRETCH;
          w_cnt_nxt = '0;
        end
      end
      S_STRETCH: begin
        // Re-request wins over the final stretch cycle; output already high,
        // so no filtering and no event count.
        if (w_req)                 w_nxt = S_ASSERT;
        else if (r_cnt == ST_LAST) w_nxt = S_IDLE;
        else                       w_cnt_nxt = r_cnt + CW'(1);
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_STRETCH;
      r_cnt     <= '0;
      r_rst     <= 1'b1;
      r_rst_n   <= 1'b0;
      r_glitch  <= 1'b0;
      r_rst_cnt <= '0;
    end else begin
      r_state  <= w_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rst    <=  ((w_nxt == S_ASSERT) || (w_nxt == S_STRETCH));
      r_rst_n  <= !((w_nxt == S_ASSERT) || (w_nxt == S_STRETCH));
      r_glitch <= w_glitch;
      if (w_inc && (r_rst_cnt != '1)) r_rst_cnt <= r_rst_cnt + CNT_W'(1);
    end
  end

  assign rst_o     = r_rst;
  assign rst_n_o   = r_rst_n;
  assign glitch_o  = r_glitch;
  assign rst_cnt_o = r_rst_cnt;
  assign busy_o    = (r_state != S_IDLE);

`ifdef DVS_RST_REQ_RX_WIDTH_MEAS_EN
  // r_wcnt runs while the request is active; r_width captures it when the
  // FSM sees the request drop (glitches included).
  logic [CNT_W-1:0] r_wcnt, r_width;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wcnt  <= '0;
      r_width <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_STRETCH: begin
          if (w_req) r_wcnt <= CNT_W'(1);
        end
        S_FILTER, S_ASSERT: begin
          if (w_req) begin
            if (r_wcnt != '1) r_wcnt <= r_wcnt + CNT_W'(1);
          end else begin
            r_width <= r_wcnt;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_width_o = r_width;
`endif

endmodule
